// File: rtl/cache_miss_ctrl.sv
// L1 D-cache miss sequencer: lookup, victim write-back, refill, tag update.
// Define CACHE_MISS_CTRL_CWF_EN for critical-word-first refill order.
module cache_miss_ctrl #(
  parameter int PA_WIDTH  = 32,
  parameter int IDX_WIDTH = 7,
  parameter int TAG_WIDTH = 19,
  parameter int WAY_WIDTH = 2,
  parameter int BEATS     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [PA_WIDTH-1:0]  req_addr,
  input  logic                 req_we,
  output logic                 resp_valid,
  input  logic                 lk_hit,
  input  logic [WAY_WIDTH-1:0] lk_hit_way,
  input  logic [WAY_WIDTH-1:0] vic_way,
  input  logic                 vic_valid,
  input  logic                 vic_dirty,
  input  logic [TAG_WIDTH-1:0] vic_tag,
  output logic                 lk_en,
  output logic                 tag_we,
  output logic [WAY_WIDTH-1:0] tag_way,
  output logic                 tag_valid,
  output logic                 lru_touch,
  output logic [WAY_WIDTH-1:0] arr_way,
  output logic [3:0]           arr_beat,
  output logic                 arr_we,
  output logic                 cpu_acc,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [PA_WIDTH-1:0]  mem_addr,
  input  logic                 mem_ack
);

  localparam int OFF = PA_WIDTH - TAG_WIDTH - IDX_WIDTH;
  localparam logic [3:0] LAST = 4'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_REFILL,
    S_UPDATE,
    S_RESP
  } state_e;

  state_e                 state_q, state_d;
  logic [PA_WIDTH-1:0]    addr_q, addr_d;
  logic [3:0]             beat_q, beat_d;
  logic [WAY_WIDTH-1:0]   vway_q, vway_d;
  logic [TAG_WIDTH-1:0]   vtag_q, vtag_d;

  logic [TAG_WIDTH-1:0]   req_tag;
  logic [IDX_WIDTH-1:0]   req_idx;
  logic [3:0]             rf_start;
  logic [3:0]             rf_last;
  logic [PA_WIDTH-1:0]    wb_addr;
  logic [PA_WIDTH-1:0]    rf_addr;

  // Word select and store flag are consumed by the data array directly.
  logic unused_ok;
  assign unused_ok = ^{addr_q[1:0], req_we};

  assign req_tag = addr_q[PA_WIDTH-1 -: TAG_WIDTH];
  assign req_idx = addr_q[OFF +: IDX_WIDTH];

`ifdef CACHE_MISS_CTRL_CWF_EN
  assign rf_start = addr_q[5:2];
`else
  assign rf_start = 4'd0;
`endif

  // Sixteen beats from the start wrap back to one before it.
  assign rf_last = rf_start + LAST;

  assign wb_addr = {vtag_q, req_idx, beat_q, 2'b00};
  assign rf_addr = {req_tag, req_idx, beat_q, 2'b00};

  // State and transaction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      vway_q  <= '0;
      vtag_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      vway_q  <= vway_d;
      vtag_q  <= vtag_d;
    end
  end

  // Next state and array/memory strobes; reset forces idle outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    vway_d     = vway_q;
    vtag_d     = vtag_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    lk_en      = 1'b0;
    tag_we     = 1'b0;
    tag_way    = '0;
    tag_valid  = 1'b0;
    lru_touch  = 1'b0;
    arr_way    = '0;
    arr_beat   = '0;
    arr_we     = 1'b0;
    cpu_acc    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          lk_en   = 1'b1;
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (lk_hit) begin
          lru_touch = 1'b1;
          cpu_acc   = 1'b1;
          arr_way   = lk_hit_way;
          arr_beat  = addr_q[5:2];
          state_d   = S_RESP;
        end else begin
          vway_d = vic_way;
          vtag_d = vic_tag;
          if (vic_valid && vic_dirty) begin
            beat_d  = '0;
            state_d = S_WB;
          end else begin
            tag_we  = 1'b1;
            tag_way = vic_way;
            beat_d  = rf_start;
            state_d = S_REFILL;
          end
        end
      end

      S_WB: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = wb_addr;
        arr_way  = vway_q;
        arr_beat = beat_q;
        if (mem_ack) begin
          beat_d = beat_q + 4'd1;
          if (beat_q == LAST) begin
            tag_we  = 1'b1;
            tag_way = vway_q;
            beat_d  = rf_start;
            state_d = S_REFILL;
          end
        end
      end

      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = rf_addr;
        arr_way  = vway_q;
        arr_beat = beat_q;
        if (mem_ack) begin
          arr_we = 1'b1;
          beat_d = beat_q + 4'd1;
          if (beat_q == rf_last) begin
            state_d = S_UPDATE;
          end
        end
      end

      S_UPDATE: begin
        tag_we    = 1'b1;
        tag_valid = 1'b1;
        tag_way   = vway_q;
        lk_en     = 1'b1;
        state_d   = S_LOOKUP;
      end

      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (rst) begin
      req_ready  = 1'b1;
      resp_valid = 1'b0;
      lk_en      = 1'b0;
      tag_we     = 1'b0;
      tag_way    = '0;
      tag_valid  = 1'b0;
      lru_touch  = 1'b0;
      arr_way    = '0;
      arr_beat   = '0;
      arr_we     = 1'b0;
      cpu_acc    = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl: hit, clean/dirty miss,
// refill stall, reset mid-refill and refill beat order.
module tb_cache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic        resp_valid;
  logic        lk_hit;
  logic [1:0]  lk_hit_way;
  logic [1:0]  vic_way;
  logic        vic_valid;
  logic        vic_dirty;
  logic [18:0] vic_tag;
  logic        lk_en;
  logic        tag_we;
  logic [1:0]  tag_way;
  logic        tag_valid;
  logic        lru_touch;
  logic [1:0]  arr_way;
  logic [3:0]  arr_beat;
  logic        arr_we;
  logic        cpu_acc;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic        mem_ack;

  int nchk = 0;
  int nfail = 0;

  cache_miss_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .resp_valid (resp_valid),
    .lk_hit     (lk_hit),
    .lk_hit_way (lk_hit_way),
    .vic_way    (vic_way),
    .vic_valid  (vic_valid),
    .vic_dirty  (vic_dirty),
    .vic_tag    (vic_tag),
    .lk_en      (lk_en),
    .tag_we     (tag_we),
    .tag_way    (tag_way),
    .tag_valid  (tag_valid),
    .lru_touch  (lru_touch),
    .arr_way    (arr_way),
    .arr_beat   (arr_beat),
    .arr_we     (arr_we),
    .cpu_acc    (cpu_acc),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_chk(input string nm);
    chk({nm, ":ready"}, req_ready, 1);
    chk({nm, ":resp"}, resp_valid, 0);
    chk({nm, ":lk_en"}, lk_en, 0);
    chk({nm, ":tag_we"}, tag_we, 0);
    chk({nm, ":tag_v"}, tag_valid, 0);
    chk({nm, ":arr_we"}, arr_we, 0);
    chk({nm, ":cpu_acc"}, cpu_acc, 0);
    chk({nm, ":lru"}, lru_touch, 0);
    chk({nm, ":mreq"}, mem_req, 0);
    chk({nm, ":mwe"}, mem_we, 0);
    chk({nm, ":maddr"}, mem_addr, 0);
    chk({nm, ":aw"}, arr_way, 0);
    chk({nm, ":ab"}, arr_beat, 0);
    chk({nm, ":tw"}, tag_way, 0);
  endtask

  // One CPU request; tag array and memory are modelled inline.
  // rst_at >= 0 asserts reset before that refill beat is acked.
  task automatic txn(input string nm,
                     input logic [31:0] a,
                     input logic hit,
                     input logic dirty,
                     input logic [18:0] vt,
                     input logic [1:0] vw,
                     input int stall,
                     input int rst_at,
                     input int exp_lat);
    int cyc, nrf, nwb, ninv, nval, nhit, lkn, sleft, lat;
    logic pend, done, stl;
    logic [3:0] rb, wbt;
    logic [31:0] ea;
    cyc = 0; nrf = 0; nwb = 0; ninv = 0; nval = 0;
    nhit = 0; lkn = 0; sleft = stall; lat = -1;
    pend = 0; done = 0; wbt = 0; rb = 4'd0;
`ifdef CACHE_MISS_CTRL_CWF_EN
    rb = a[5:2];
`endif
    vic_way = vw; vic_tag = vt;
    vic_valid = 1'b1; vic_dirty = dirty;
    lk_hit_way = vw;
    while (!done && cyc < 200) begin
      req_valid = (cyc < 2);
      req_addr = a;
      req_we = 1'b0;
      lk_hit = pend && (hit || lkn > 1);
      mem_ack = 1'b1;
      stl = 1'b0;
      if (nrf == 8 && sleft > 0) begin
        mem_ack = 1'b0;
        stl = 1'b1;
        sleft--;
      end
      rst = (rst_at >= 0 && nrf == rst_at);
      #1;
      if (rst) begin
        chk({nm, ":rst_mreq"}, mem_req, 0);
        chk({nm, ":rst_tagwe"}, tag_we, 0);
        chk({nm, ":rst_arrwe"}, arr_we, 0);
        done = 1'b1;
      end else begin
        if (cyc == 0) begin
          chk({nm, ":acc_ready"}, req_ready, 1);
          chk({nm, ":acc_lken"}, lk_en, 1);
        end
        if (cyc == 1) chk({nm, ":busy_ready"}, req_ready, 0);
        if (lru_touch) begin
          nhit++;
          chk({nm, ":hit_acc"}, cpu_acc, 1);
          chk({nm, ":hit_way"}, arr_way, vw);
          chk({nm, ":hit_beat"}, arr_beat, a[5:2]);
        end
        if (stl) begin
          chk({nm, ":stall_mreq"}, mem_req, 1);
          chk({nm, ":stall_we"}, arr_we, 0);
        end
        if (mem_req && mem_ack) begin
          if (mem_we) begin
            ea = {vt, a[12:6], wbt, 2'b00};
            chk({nm, ":wb_addr"}, mem_addr, ea);
            chk({nm, ":wb_beat"}, arr_beat, wbt);
            chk({nm, ":wb_way"}, arr_way, vw);
            wbt++;
            nwb++;
          end else begin
            ea = {a[31:6], rb, 2'b00};
            chk({nm, ":rf_addr"}, mem_addr, ea);
            chk({nm, ":rf_we"}, arr_we, 1);
            chk({nm, ":rf_beat"}, arr_beat, rb);
            rb++;
            nrf++;
          end
        end
        if (tag_we) begin
          chk({nm, ":tag_way"}, tag_way, vw);
          if (tag_valid) begin
            nval++;
            chk({nm, ":val_after_rf"}, nrf, 16);
          end else begin
            ninv++;
            chk({nm, ":inv_after_wb"}, nwb, dirty ? 16 : 0);
          end
        end
        if (resp_valid) begin
          lat = cyc;
          done = 1'b1;
        end
      end
      pend = lk_en;
      if (lk_en) lkn++;
      @(negedge clk);
      cyc++;
    end
    rst = 1'b0;
    req_valid = 1'b0;
    mem_ack = 1'b0;
    lk_hit = 1'b0;
    chk({nm, ":done"}, done, 1);
    if (rst_at < 0) begin
      chk({nm, ":lat"}, lat, exp_lat);
      chk({nm, ":n_rf"}, nrf, hit ? 0 : 16);
      chk({nm, ":n_wb"}, nwb, (!hit && dirty) ? 16 : 0);
      chk({nm, ":n_inv"}, ninv, hit ? 0 : 1);
      chk({nm, ":n_val"}, nval, hit ? 0 : 1);
      chk({nm, ":n_hit"}, nhit, 1);
      #1;
      chk({nm, ":end_ready"}, req_ready, 1);
      chk({nm, ":end_resp"}, resp_valid, 0);
    end else begin
      chk({nm, ":n_val"}, nval, 0);
      #1;
      idle_chk({nm, ":post"});
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        #1;
        chk({nm, ":quiet_tagwe"}, tag_we, 0);
        chk({nm, ":quiet_mreq"}, mem_req, 0);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'h0000_1A48;
    req_we = 1'b0;
    lk_hit = 1'b0;
    lk_hit_way = 2'd0;
    vic_way = 2'd0;
    vic_valid = 1'b0;
    vic_dirty = 1'b0;
    vic_tag = '0;
    mem_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    idle_chk("in_rst");
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    mem_ack = 1'b0;
    #1;
    idle_chk("rst_idle");
    @(negedge clk);

    txn("hit",   32'h1234_5678, 1'b1, 1'b0, 19'h7, 2'd2, 0, -1, 2);
    txn("clean", 32'h0000_1A48, 1'b0, 1'b0, 19'h7, 2'd1, 0, -1, 20);
    txn("dirty", 32'h0000_1A48, 1'b0, 1'b1, 19'h5, 2'd3, 0, -1, 36);
    txn("stall", 32'h0000_1A48, 1'b0, 1'b0, 19'h2, 2'd0, 3, -1, 23);
    txn("rstmid", 32'h0000_1A48, 1'b0, 1'b0, 19'h2, 2'd1, 0, 7, 0);
    txn("cwf",   32'h8000_0374, 1'b0, 1'b0, 19'h9, 2'd2, 0, -1, 20);
    txn("dcwf",  32'h8000_0374, 1'b0, 1'b1, 19'h4, 2'd1, 0, -1, 36);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
